// File: rtl/reg_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_bus_pkg
// Brief    : Shared types and default sizes for the register-bus master.
// Revision : 1.0 - initial release
// ============================================================================
package reg_bus_pkg;

    localparam int AW_DEFAULT    = 3;
    localparam int DW_DEFAULT    = 8;
    localparam int DEPTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_e;

    typedef struct packed {
        logic                  wr;
        logic [AW_DEFAULT-1:0] addr;
        logic [DW_DEFAULT-1:0] data;
    } cmd_t;

endpackage
`default_nettype wire

// File: rtl/reg_bus_fifo.sv
`default_nettype none
// ============================================================================
// Module   : reg_bus_fifo
// Brief    : Synchronous command FIFO; full/empty split by an extra pointer bit.
// Revision : 1.0 - initial release
// ============================================================================
module reg_bus_fifo #(
    parameter int W     = 12,
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0] wr_ptr_q;
    logic [PTR_W:0] rd_ptr_q;
    logic [W-1:0]   mem_q [DEPTH];
    logic           w_push;
    logic           w_pop;

    // A push is refused while full even if a pop happens in the same cycle.
    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && !empty_o;
    assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign rdata_o = mem_q[rd_ptr_q[PTR_W-1:0]];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + (PTR_W+1)'(1);
            if (w_pop)  rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= wdata_i;
    end

endmodule
`default_nettype wire

// File: rtl/reg_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : reg_bus_master
// Brief    : Queues read/write commands and plays them onto a register-file
//            bus one at a time, returning read data on a response channel.
//            Define REG_BUS_MASTER_CNT_EN to add write/read issue counters.
// Revision : 1.0 - initial release
// ============================================================================
module reg_bus_master
    import reg_bus_pkg::*;
#(
    parameter int AW    = AW_DEFAULT,
    parameter int DW    = DW_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          cmd_valid_i,
    output logic          cmd_ready_o,
    input  logic          cmd_wr_i,
    input  logic [AW-1:0] cmd_addr_i,
    input  logic [DW-1:0] cmd_data_i,
    output logic          bus_wen_o,
    output logic          bus_oen_o,
    output logic [AW-1:0] bus_addr_o,
    output logic [DW-1:0] bus_din_o,
    input  logic [DW-1:0] bus_dout_i,
    output logic          rsp_valid_o,
    input  logic          rsp_ready_i,
    output logic [AW-1:0] rsp_addr_o,
    output logic [DW-1:0] rsp_data_o,
    output logic          busy_o
`ifdef REG_BUS_MASTER_CNT_EN
    ,
    output logic [15:0]   wr_cnt_o,
    output logic [15:0]   rd_cnt_o
`endif
);

    localparam int CMD_W = 1 + AW + DW;

    state_e        state_q, state_d;
    logic          bus_wen_q, bus_wen_d;
    logic          bus_oen_q, bus_oen_d;
    logic [AW-1:0] bus_addr_q, bus_addr_d;
    logic [DW-1:0] bus_din_q, bus_din_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [AW-1:0] rsp_addr_q, rsp_addr_d;
    logic [DW-1:0] rsp_data_q, rsp_data_d;

    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_pop;
    logic [CMD_W-1:0] w_head;
    logic             w_head_wr;
    logic [AW-1:0]    w_head_addr;
    logic [DW-1:0]    w_head_data;

    reg_bus_fifo #(
        .W     (CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (cmd_valid_i),
        .wdata_i ({cmd_wr_i, cmd_addr_i, cmd_data_i}),
        .pop_i   (w_pop),
        .rdata_o (w_head),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty)
    );

    assign w_head_wr   = w_head[CMD_W-1];
    assign w_head_addr = w_head[DW +: AW];
    assign w_head_data = w_head[DW-1:0];

    always_comb begin
        state_d     = state_q;
        bus_wen_d   = 1'b0;
        bus_oen_d   = 1'b0;
        bus_addr_d  = bus_addr_q;
        bus_din_d   = bus_din_q;
        rsp_valid_d = rsp_valid_q;
        rsp_addr_d  = rsp_addr_q;
        rsp_data_d  = rsp_data_q;
        w_pop       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop      = 1'b1;
                    bus_wen_d  = w_head_wr;
                    bus_oen_d  = !w_head_wr;
                    bus_addr_d = w_head_addr;
                    if (w_head_wr) bus_din_d = w_head_data;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                state_d = bus_wen_q ? IDLE : CAPTURE;
            end
            // The register file presents read data one cycle after BUS_OEN.
            CAPTURE: begin
                rsp_valid_d = 1'b1;
                rsp_addr_d  = bus_addr_q;
                rsp_data_d  = bus_dout_i;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            bus_wen_q   <= 1'b0;
            bus_oen_q   <= 1'b0;
            bus_addr_q  <= '0;
            bus_din_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_addr_q  <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            bus_wen_q   <= bus_wen_d;
            bus_oen_q   <= bus_oen_d;
            bus_addr_q  <= bus_addr_d;
            bus_din_q   <= bus_din_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign cmd_ready_o = !w_fifo_full;
    assign bus_wen_o   = bus_wen_q;
    assign bus_oen_o   = bus_oen_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_din_o   = bus_din_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_addr_o  = rsp_addr_q;
    assign rsp_data_o  = rsp_data_q;
    assign busy_o      = (state_q != IDLE) || !w_fifo_empty;

`ifdef REG_BUS_MASTER_CNT_EN
    logic [15:0] wr_cnt_q;
    logic [15:0] rd_cnt_q;

    // Counters wrap naturally through 16-bit overflow.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else if (state_q == ISSUE) begin
            if (bus_wen_q) wr_cnt_q <= wr_cnt_q + 16'd1;
            if (bus_oen_q) rd_cnt_q <= rd_cnt_q + 16'd1;
        end
    end

    assign wr_cnt_o = wr_cnt_q;
    assign rd_cnt_o = rd_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_bus_master
// Brief    : Self-checking bench for reg_bus_master with a register-file model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_bus_master;
    import reg_bus_pkg::*;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_wr    = 1'b0;
    logic [2:0] cmd_addr  = '0;
    logic [7:0] cmd_data  = '0;
    logic       rsp_ready = 1'b0;
    logic       cmd_ready;
    logic       bus_wen, bus_oen;
    logic [2:0] bus_addr;
    logic [7:0] bus_din;
    logic [7:0] bus_dout = '0;
    logic       rsp_valid;
    logic [2:0] rsp_addr;
    logic [7:0] rsp_data;
    logic       busy;
`ifdef REG_BUS_MASTER_CNT_EN
    logic [15:0] wr_cnt, rd_cnt;
`endif

    always #5 clk = ~clk;

    reg_bus_master u_dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_wr_i    (cmd_wr),
        .cmd_addr_i  (cmd_addr),
        .cmd_data_i  (cmd_data),
        .bus_wen_o   (bus_wen),
        .bus_oen_o   (bus_oen),
        .bus_addr_o  (bus_addr),
        .bus_din_o   (bus_din),
        .bus_dout_i  (bus_dout),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_addr_o  (rsp_addr),
        .rsp_data_o  (rsp_data),
        .busy_o      (busy)
`ifdef REG_BUS_MASTER_CNT_EN
        ,
        .wr_cnt_o    (wr_cnt),
        .rd_cnt_o    (rd_cnt)
`endif
    );

    // Register file: commits writes and registers read data on the enable edge.
    logic [7:0] rf [8] = '{default: 8'h00};
    always @(posedge clk) begin
        if (bus_wen) rf[bus_addr] <= bus_din;
        if (bus_oen) bus_dout <= rf[bus_addr];
    end

    // Reference: memory image in acceptance order plus expected bus/response queues.
    logic [7:0] ref_mem [8] = '{default: 8'h00};
    cmd_t       bus_q[$];
    cmd_t       rsp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_rsp    = 0;
    int         rdy_mode = 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic ready_drv();
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       rsp_ready = 1'b0;
                1:       rsp_ready = 1'b1;
                default: rsp_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    endtask

    task automatic monitor();
        cmd_t op;
        logic prev_op   = 1'b0;
        logic prev_hold = 1'b0;
        logic [2:0] prev_addr = '0;
        logic [7:0] prev_data = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_op   = 1'b0;
                prev_hold = 1'b0;
            end else begin
                if (cmd_valid && cmd_ready) begin
                    op.wr   = cmd_wr;
                    op.addr = cmd_addr;
                    op.data = cmd_data;
                    bus_q.push_back(op);
                    if (cmd_wr) ref_mem[cmd_addr] = cmd_data;
                    else begin
                        op.data = ref_mem[cmd_addr];
                        rsp_q.push_back(op);
                    end
                end
                if (bus_wen || bus_oen) begin
                    check("bus_excl", 32'(bus_wen & bus_oen), 0);
                    check("bus_one_cycle", 32'(prev_op), 0);
                    if (bus_q.size() == 0) check("bus_unexpected", 1, 0);
                    else begin
                        op = bus_q.pop_front();
                        check("bus_kind", 32'(bus_wen), 32'(op.wr));
                        check("bus_addr", 32'(bus_addr), 32'(op.addr));
                        if (op.wr) check("bus_din", 32'(bus_din), 32'(op.data));
                    end
                end
                prev_op = bus_wen | bus_oen;
                if (rsp_valid) check("rsp_bus_quiet", 32'(bus_wen | bus_oen), 0);
                if (prev_hold) begin
                    check("rsp_hold_valid", 32'(rsp_valid), 1);
                    check("rsp_hold_addr", 32'(rsp_addr), 32'(prev_addr));
                    check("rsp_hold_data", 32'(rsp_data), 32'(prev_data));
                end
                if (rsp_valid && rsp_ready) begin
                    n_rsp++;
                    if (rsp_q.size() == 0) check("rsp_unexpected", 1, 0);
                    else begin
                        op = rsp_q.pop_front();
                        check("rsp_addr", 32'(rsp_addr), 32'(op.addr));
                        check("rsp_data", 32'(rsp_data), 32'(op.data));
                    end
                end
                prev_hold = rsp_valid && !rsp_ready;
                prev_addr = rsp_addr;
                prev_data = rsp_data;
            end
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic wr, input logic [2:0] a, input logic [7:0] d, output int waits);
        cmd_wr    = wr;
        cmd_addr  = a;
        cmd_data  = d;
        cmd_valid = 1'b1;
        waits     = 0;
        @(negedge clk);
        while (!cmd_ready && waits < 100) begin
            waits++;
            @(negedge clk);
        end
        if (!cmd_ready) check("cmd_accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        @(negedge clk);
        while ((busy || bus_q.size() != 0 || rsp_q.size() != 0) && k < 400) begin
            k++;
            @(negedge clk);
        end
        if (k >= 400) check("drain_timeout", 1, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int         w;
        int         base;
        int         gap;
        logic [2:0] a;
        logic [7:0] d;

        fork
            monitor();
            ready_drv();
        join_none

        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_wen", 32'(bus_wen), 0);
        check("rst_oen", 32'(bus_oen), 0);
        check("rst_bus_addr", 32'(bus_addr), 0);
        check("rst_bus_din", 32'(bus_din), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_addr", 32'(rsp_addr), 0);
        check("rst_rsp_data", 32'(rsp_data), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Write A5 to 3, then read it back with exact latencies.
        send(1'b1, 3'd3, 8'hA5, w);
        @(negedge clk); check("wr_lat_pre", 32'(bus_wen), 0);
        @(negedge clk); check("wr_lat_wen", 32'(bus_wen), 1);
        check("wr_lat_addr", 32'(bus_addr), 3);
        check("wr_lat_din", 32'(bus_din), 32'h A5);
        @(negedge clk); check("wr_lat_post", 32'(bus_wen), 0);
        wait_idle();
        send(1'b0, 3'd3, 8'h00, w);
        @(negedge clk); check("rd_lat_pre", 32'(bus_oen), 0);
        @(negedge clk); check("rd_lat_oen", 32'(bus_oen), 1);
        check("rd_lat_addr", 32'(bus_addr), 3);
        @(negedge clk); check("rd_lat_capture", 32'(rsp_valid), 0);
        @(negedge clk); check("rd_lat_valid", 32'(rsp_valid), 1);
        check("rd_lat_rsp_addr", 32'(rsp_addr), 3);
        check("rd_lat_rsp_data", 32'(rsp_data), 32'h A5);
        wait_idle();

        // Stall in RESP, hold 10 cycles, then fill the FIFO behind it.
        rdy_mode = 0;
        send(1'b0, 3'd6, 8'h00, w);
        for (int k = 0; k < 10 && !rsp_valid; k++) @(negedge clk);
        check("stall_rsp_rise", 32'(rsp_valid), 1);
        a = rsp_addr;
        d = rsp_data;
        check("stall_rsp_addr", 32'(a), 6);
        repeat (10) begin
            @(negedge clk);
            check("stall_valid", 32'(rsp_valid), 1);
            check("stall_addr", 32'(rsp_addr), 32'(a));
            check("stall_data", 32'(rsp_data), 32'(d));
            check("stall_oen", 32'(bus_oen), 0);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            send(1'b1, 3'($urandom), 8'($urandom), w);
            check("fill_wait", 32'(w), 0);
        end
        cmd_wr    = 1'b1;
        cmd_addr  = 3'($urandom);
        cmd_data  = 8'($urandom);
        cmd_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("full_ready", 32'(cmd_ready), 0);
        end
        check("full_busy", 32'(busy), 1);
        @(posedge clk);
        #1;
        rdy_mode = 1;
        @(negedge clk); check("pop_ready_hs", 32'(cmd_ready), 0);
        @(negedge clk); check("pop_ready_popcyc", 32'(cmd_ready), 0);
        @(negedge clk); check("pop_ready_after", 32'(cmd_ready), 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        wait_idle();

        // Writes 0..7 then reads 7..0 to wrap the pointers.
        base = n_rsp;
        for (int i = 0; i < 8; i++) send(1'b1, 3'(i), 8'($urandom), w);
        for (int i = 7; i >= 0; i--) send(1'b0, 3'(i), 8'h00, w);
        wait_idle();
        check("wrap_rsp_count", 32'(n_rsp - base), 8);
        check("wrap_busy", 32'(busy), 0);

        // Random traffic with random response backpressure.
        rdy_mode = 2;
        repeat (80) begin
            send(1'($urandom), 3'($urandom), 8'($urandom), w);
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                repeat (gap) @(posedge clk);
                #1;
            end
        end
        wait_idle();
        rdy_mode = 1;

        // Reset in the ISSUE cycle of a write, with a read still queued.
        send(1'b1, 3'd5, 8'h3C, w);
        send(1'b0, 3'd2, 8'h00, w);
        check("rst_issue_wen_pre", 32'(bus_wen), 1);
        check("rst_issue_addr_pre", 32'(bus_addr), 5);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_issue_wen", 32'(bus_wen), 0);
        check("rst_issue_oen", 32'(bus_oen), 0);
        check("rst_issue_ready", 32'(cmd_ready), 1);
        check("rst_issue_busy", 32'(busy), 0);
        check("rst_issue_addr", 32'(bus_addr), 0);
        rst = 1'b0;
        bus_q.delete();
        rsp_q.delete();
        send(1'b0, 3'd5, 8'h00, w);
        wait_idle();

`ifdef REG_BUS_MASTER_CNT_EN
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("cnt_rst_wr", 32'(wr_cnt), 0);
        check("cnt_rst_rd", 32'(rd_cnt), 0);
        send(1'b1, 3'd1, 8'h11, w);
        send(1'b0, 3'd1, 8'h00, w);
        send(1'b1, 3'd2, 8'h22, w);
        send(1'b1, 3'd4, 8'h44, w);
        send(1'b0, 3'd4, 8'h00, w);
        wait_idle();
        check("cnt_wr", 32'(wr_cnt), 3);
        check("cnt_rd", 32'(rd_cnt), 2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("cnt_clr_wr", 32'(wr_cnt), 0);
        check("cnt_clr_rd", 32'(rd_cnt), 0);
`endif

        check("final_bus_q", 32'(bus_q.size()), 0);
        check("final_rsp_q", 32'(rsp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
